// File: rtl/req_ack_checker.sv
// Request/acknowledge protocol checker: per-channel latency tracking with
// pass/fail/overlap pulses and aggregate saturating event counters.
`timescale 1ns/1ps

module req_ack_channel #(
    parameter int MAX_LAT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       ack,
    output logic       pass_evt,
    output logic       fail_evt,
    output logic       ovl_evt,
    output logic       pass,
    output logic       fail,
    output logic       ovl,
    output logic [7:0] lat
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [7:0] MAX_LAT_V = 8'(MAX_LAT);

    state_t     state;
    state_t     state_nx;
    logic [7:0] elapsed;
    logic [7:0] elapsed_nx;
    logic [7:0] elapsed_inc;
    logic [7:0] lat_nx;
    logic       req_d;
    logic       rise;

    assign rise        = req & ~req_d;
    assign elapsed_inc = elapsed + 8'd1;

    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    always_comb begin
        state_nx   = state;
        elapsed_nx = elapsed;
        lat_nx     = lat;
        pass_evt   = 1'b0;
        fail_evt   = 1'b0;
        ovl_evt    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx   = WAIT;
                    elapsed_nx = 8'd0;
                end
            end
            WAIT: begin
                if (ack) begin
                    pass_evt   = 1'b1;
                    lat_nx     = elapsed_inc;
                    state_nx   = IDLE;
                    elapsed_nx = 8'd0;
                end else if (elapsed_inc == MAX_LAT_V) begin
                    fail_evt   = 1'b1;
                    state_nx   = IDLE;
                    elapsed_nx = 8'd0;
                end else begin
                    elapsed_nx = elapsed_inc;
                end
                // A rise on the resolving edge starts a fresh request instead of overlapping.
                if (rise) begin
                    if (pass_evt || fail_evt) begin
                        state_nx   = WAIT;
                        elapsed_nx = 8'd0;
                    end else begin
                        ovl_evt = 1'b1;
                    end
                end
            end
            default: begin
                state_nx   = IDLE;
                elapsed_nx = 8'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            elapsed <= 8'd0;
            req_d   <= 1'b0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            ovl     <= 1'b0;
            lat     <= 8'd0;
        end else begin
            state   <= state_nx;
            elapsed <= elapsed_nx;
            req_d   <= req;
            pass    <= pass_evt;
            fail    <= fail_evt;
            ovl     <= ovl_evt;
            lat     <= lat_nx;
        end
    end

endmodule

module req_ack_sat_counter #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [NUM_CH-1:0] evt,
    output logic [CNT_W-1:0]  cnt
);

    // Five spare bits cover a popcount of up to 16 channels without overflow.
    localparam int SUM_W = CNT_W + 5;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [4:0]       pop;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_nx;

    always_comb begin
        pop = 5'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + 5'(evt[i]);
        end
        sum    = SUM_W'(cnt) + SUM_W'(pop);
        cnt_nx = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nx;
        end
    end

endmodule

module req_ack_checker #(
    parameter int NUM_CH  = 2,
    parameter int MAX_LAT = 8,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   req,
    input  logic [NUM_CH-1:0]   ack,
    input  logic                cnt_clr,
    output logic [NUM_CH-1:0]   pass,
    output logic [NUM_CH-1:0]   fail,
    output logic [NUM_CH-1:0]   ovl,
    output logic [NUM_CH*8-1:0] lat,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic [CNT_W-1:0]    fail_cnt,
    output logic [CNT_W-1:0]    ovl_cnt
);

    // Same-edge decisions feed the counters so they update alongside the pulse registers.
    logic [NUM_CH-1:0] pass_evt;
    logic [NUM_CH-1:0] fail_evt;
    logic [NUM_CH-1:0] ovl_evt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        req_ack_channel #(
            .MAX_LAT (MAX_LAT)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .req      (req[g]),
            .ack      (ack[g]),
            .pass_evt (pass_evt[g]),
            .fail_evt (fail_evt[g]),
            .ovl_evt  (ovl_evt[g]),
            .pass     (pass[g]),
            .fail     (fail[g]),
            .ovl      (ovl[g]),
            .lat      (lat[g*8 +: 8])
        );
    end

    req_ack_sat_counter #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .evt (pass_evt),
        .cnt (pass_cnt)
    );

    req_ack_sat_counter #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_fail_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .evt (fail_evt),
        .cnt (fail_cnt)
    );

    req_ack_sat_counter #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_ovl_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .evt (ovl_evt),
        .cnt (ovl_cnt)
    );

endmodule

// File: tb/tb_req_ack_checker.sv
// Directed self-checking bench for req_ack_checker (NUM_CH=2, MAX_LAT=8, CNT_W=8).
`timescale 1ns/1ps

module tb_req_ack_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  ack = 2'b00;
    logic        cnt_clr = 1'b0;
    logic [1:0]  pass;
    logic [1:0]  fail;
    logic [1:0]  ovl;
    logic [15:0] lat;
    logic [7:0]  pass_cnt;
    logic [7:0]  fail_cnt;
    logic [7:0]  ovl_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    req_ack_checker #(
        .NUM_CH  (2),
        .MAX_LAT (8),
        .CNT_W   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ack      (ack),
        .cnt_clr  (cnt_clr),
        .pass     (pass),
        .fail     (fail),
        .ovl      (ovl),
        .lat      (lat),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .ovl_cnt  (ovl_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks = n_checks + 1;
        assert (observed === expected) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic check_pulses(input string tag, input logic [1:0] p, input logic [1:0] f, input logic [1:0] o);
        check({tag, "_pass"}, 32'(pass), 32'(p));
        check({tag, "_fail"}, 32'(fail), 32'(f));
        check({tag, "_ovl"},  32'(ovl),  32'(o));
    endtask

    logic fail_seen;

    initial begin
        // Reset state.
        #2;
        check_pulses("rst", 2'b00, 2'b00, 2'b00);
        check("rst_lat", 32'(lat), 32'h0);
        check("rst_cnts", {8'h0, pass_cnt, fail_cnt, ovl_cnt}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // ch0: rise at edge 1, drop at edge 2, ack at edge 4 and edge 7.
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        tick();
        check_pulses("w_e3", 2'b00, 2'b00, 2'b00);
        ack = 2'b01;
        tick();
        check_pulses("match_e4", 2'b01, 2'b00, 2'b00);
        check("match_lat", 32'(lat[7:0]), 32'd3);
        check("match_pcnt", 32'(pass_cnt), 32'd1);
        ack = 2'b00;
        tick();
        check("pulse_len", 32'(pass), 32'd0);
        tick();
        ack = 2'b01;
        tick();
        check("idle_ack_pass", 32'(pass), 32'd0);
        check("idle_ack_pcnt", 32'(pass_cnt), 32'd1);
        check("idle_ack_lat", 32'(lat[7:0]), 32'd3);
        ack = 2'b00;

        // ch1: ack at the rise edge is ignored, then timeout 8 edges later.
        req = 2'b10;
        ack = 2'b10;
        tick();
        check("rise_ack_pass", 32'(pass), 32'd0);
        ack = 2'b00;
        for (int i = 1; i <= 7; i++) tick();
        check_pulses("pre_to", 2'b00, 2'b00, 2'b00);
        tick();
        check_pulses("timeout", 2'b00, 2'b10, 2'b00);
        check("timeout_fcnt", 32'(fail_cnt), 32'd1);
        tick();
        check("fail_len", 32'(fail), 32'd0);
        req = 2'b00;
        tick();

        // ch1: ack at exactly MAX_LAT passes.
        req = 2'b10;
        tick();
        req = 2'b00;
        for (int i = 1; i <= 7; i++) tick();
        ack = 2'b10;
        tick();
        check_pulses("max_lat", 2'b10, 2'b00, 2'b00);
        check("max_lat_lat", 32'(lat[15:8]), 32'd8);
        ack = 2'b00;
        tick();

        // Both channels pass on the same edge at latency 2.
        req = 2'b11;
        tick();
        req = 2'b00;
        tick();
        ack = 2'b11;
        tick();
        check_pulses("both", 2'b11, 2'b00, 2'b00);
        check("both_lat", 32'(lat), {16'h0, 8'd2, 8'd2});
        check("both_pcnt", 32'(pass_cnt), 32'd4);
        ack = 2'b00;
        tick();
        check("both_len", 32'(pass), 32'd0);

        // ch0 overlap: rise at rel 0, second rise at rel 2, ack at rel 5.
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        req = 2'b01;
        tick();
        check_pulses("ovl", 2'b00, 2'b00, 2'b01);
        check("ovl_cnt", 32'(ovl_cnt), 32'd1);
        req = 2'b00;
        tick();
        check("ovl_len", 32'(ovl), 32'd0);
        tick();
        ack = 2'b01;
        tick();
        check_pulses("ovl_pass", 2'b01, 2'b00, 2'b00);
        check("ovl_lat", 32'(lat[7:0]), 32'd5);
        ack = 2'b00;
        tick();

        // ch1: rise on the timeout edge ends the old request and starts a new one.
        req = 2'b10;
        tick();
        req = 2'b00;
        for (int i = 1; i <= 7; i++) tick();
        req = 2'b10;
        tick();
        check_pulses("to_rise", 2'b00, 2'b10, 2'b00);
        check("lat_hold", 32'(lat), {16'h0, 8'd2, 8'd5});
        req = 2'b00;
        ack = 2'b10;
        tick();
        check_pulses("restart", 2'b10, 2'b00, 2'b00);
        check("restart_lat", 32'(lat[15:8]), 32'd1);
        check("cnts_mid", {8'h0, pass_cnt, fail_cnt, ovl_cnt}, {8'h0, 8'd6, 8'd2, 8'd1});
        ack = 2'b00;
        tick();

        // Reset mid-WAIT discards the request without a fail.
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_pulses("rst_mid", 2'b00, 2'b00, 2'b00);
        check("rst_mid_lat", 32'(lat), 32'h0);
        check("rst_mid_cnts", {8'h0, pass_cnt, fail_cnt, ovl_cnt}, 32'h0);
        tick();
        rst = 1'b0;
        fail_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            fail_seen = fail_seen | (|fail);
        end
        check("rst_no_fail", 32'(fail_seen), 32'd0);

        // Saturate fail and ovl: toggle req with no ack (1 fail + 3 ovl per 8 edges per channel).
        for (int i = 0; i < 1100; i++) begin
            req = ~req;
            tick();
        end
        req = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        check("sat_fcnt", 32'(fail_cnt), 32'd255);
        check("sat_ocnt", 32'(ovl_cnt), 32'd255);
        check("sat_pcnt0", 32'(pass_cnt), 32'd0);

        // Saturate pass: 280 passes.
        ack = 2'b11;
        for (int i = 0; i < 140; i++) begin
            req = 2'b11;
            tick();
            req = 2'b00;
            tick();
        end
        check("sat_pcnt", 32'(pass_cnt), 32'd255);
        req = 2'b11;
        tick();
        req = 2'b00;
        tick();
        check("sat_hold_pass", 32'(pass), 32'd3);
        check("sat_hold_pcnt", 32'(pass_cnt), 32'd255);

        // cnt_clr wins over a same-edge pass.
        req = 2'b11;
        tick();
        req = 2'b00;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_pass", 32'(pass), 32'd3);
        check("clr_cnts", {8'h0, pass_cnt, fail_cnt, ovl_cnt}, 32'h0);
        req = 2'b11;
        tick();
        req = 2'b00;
        tick();
        check("post_clr_pcnt", 32'(pass_cnt), 32'd2);
        ack = 2'b00;
        tick();

        // req held high through reset release counts as a rise at the first edge.
        rst = 1'b1;
        req = 2'b01;
        tick();
        rst = 1'b0;
        ack = 2'b01;
        tick();
        check("held_rise_ack", 32'(pass), 32'd0);
        tick();
        check("held_pass", 32'(pass), 32'd1);
        check("held_lat", 32'(lat[7:0]), 32'd1);
        req = 2'b00;
        ack = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
